// File: rtl/song_rom_arbiter_if.sv
// Request/return bus between the channel sequencers, the song ROM and
// song_rom_arbiter. master = sequencers + ROM side, slave = arbiter.
interface song_rom_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic [ADDR_W-1:0]         o_rom_addr;
  logic [DATA_W-1:0]         i_rom_data;

  modport master (
    output i_req, i_addr, i_rom_data,
    input  o_gnt, o_rvalid, o_rdata, o_rom_addr
  );

  modport slave (
    input  i_req, i_addr, i_rom_data,
    output o_gnt, o_rvalid, o_rdata, o_rom_addr
  );
endinterface

// File: rtl/song_rom_arbiter.sv
// Pipelined round-robin arbiter sharing one synchronous song ROM among NUM_REQ
// sequencers. Define SONG_ROM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module song_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ROM_LATENCY = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  song_rom_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = ROM_LATENCY + 1;

  logic [NUM_REQ-1:0]           busy_q, busy_d;
  logic [NUM_REQ-1:0]           gnt_q, gnt_d;
  logic [NUM_REQ-1:0]           rvalid_q, rvalid_d;
  logic [DATA_W-1:0]            rdata_q, rdata_d;
  logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]             pipe_vld_q, pipe_vld_d;
  logic [DEPTH-1:0][ID_W-1:0]   pipe_id_q, pipe_id_d;

  logic [NUM_REQ-1:0]           eligible;
  logic                         found;
  logic [ID_W-1:0]              winner;

`ifdef SONG_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    eligible = bus.i_req & ~busy_q;
    found    = 1'b0;
    winner   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[ID_W'(i)]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Search starts at ptr and wraps; ptr then moves just past the winner.
  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    eligible = bus.i_req & ~busy_q;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    nxt      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      nxt = 32'(winner) + 1;
      if (nxt >= NUM_REQ) nxt = 0;
      ptr_d = ID_W'(nxt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // Issue side, tag pipeline and return side.
  always_comb begin
    gnt_d = '0;
    if (found) gnt_d[winner] = 1'b1;

    rom_addr_d = found ? ADDR_W'(bus.i_addr >> (32'(winner) * ADDR_W)) : rom_addr_q;

    pipe_vld_d = {pipe_vld_q[DEPTH-2:0], found};
    pipe_id_d  = {pipe_id_q[DEPTH-2:0], winner};

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_vld_q[DEPTH-1]) begin
      rvalid_d[pipe_id_q[DEPTH-1]] = 1'b1;
      rdata_d                      = bus.i_rom_data;
    end

    // busy stays set through the o_rvalid cycle, so a requester cannot be
    // re-granted in the same cycle its data returns.
    busy_d = (busy_q & ~rvalid_q) | gnt_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q     <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rom_addr_q <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rom_addr_q <= rom_addr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_rvalid   = rvalid_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_rom_addr = rom_addr_q;
endmodule

// File: tb/tb_song_rom_arbiter.sv
// Directed self-checking bench for song_rom_arbiter (ROM_LATENCY 1 and 3).
module tb_song_rom_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) bus_a ();
  song_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) bus_b ();

  song_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .ROM_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a)
  );
  song_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .ROM_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b)
  );

  // ROM contents: word at address a is {8'hA5, a}
  function automatic logic [15:0] rom_f(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  logic [15:0] rom_a_q;
  logic [15:0] rom_b_q [3];
  always @(posedge clk) begin
    rom_a_q    <= rom_f(bus_a.o_rom_addr);
    rom_b_q[0] <= rom_f(bus_b.o_rom_addr);
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
  end
  assign bus_a.i_rom_data = rom_a_q;
  assign bus_b.i_rom_data = rom_b_q[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr_a(input int k, input logic [7:0] a);
    bus_a.i_addr = (bus_a.i_addr & ~(32'hFF << (8 * k))) | (32'(a) << (8 * k));
  endtask

  function automatic int gnt_idx(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 9;
    endcase
  endfunction

  logic [3:0] exp_g, exp_rv, g_first, g_second;
  logic [7:0] a_first, a_second;
  int         gseq [4];
  int         ng, n1;
  logic       seen;

  initial begin
    rst          = 1'b1;
    bus_a.i_req  = '0;
    bus_a.i_addr = '0;
    bus_b.i_req  = '0;
    bus_b.i_addr = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus_a.o_gnt), 0);
    chk("rst_rvalid", 32'(bus_a.o_rvalid), 0);
    chk("rst_rdata", 32'(bus_a.o_rdata), 0);
    chk("rst_rom_addr", 32'(bus_a.o_rom_addr), 0);
    rst = 1'b0;

    // single request
    set_addr_a(0, 8'h10);
    bus_a.i_req = 4'b0001;
    tick();
    chk("single_rom_addr", 32'(bus_a.o_rom_addr), 32'h10);
    chk("single_gnt", 32'(bus_a.o_gnt), 32'b0001);
    chk("single_rv_t1", 32'(bus_a.o_rvalid), 0);
    tick();
    chk("single_gnt_t2", 32'(bus_a.o_gnt), 0);
    chk("single_rv_t2", 32'(bus_a.o_rvalid), 0);
    tick();
    chk("single_rv_t3", 32'(bus_a.o_rvalid), 32'b0001);
    chk("single_rdata", 32'(bus_a.o_rdata), 32'hA510);
    bus_a.i_req = '0;
    tick();
    chk("single_rv_t4", 32'(bus_a.o_rvalid), 0);
    chk("single_rdata_hold", 32'(bus_a.o_rdata), 32'hA510);

    // all four from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_addr_a(0, 8'h00);
    set_addr_a(1, 8'h11);
    set_addr_a(2, 8'h22);
    set_addr_a(3, 8'h33);
    bus_a.i_req = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_g  = (i <= 4) ? 4'(1 << (i - 1)) : 4'b0000;
      exp_rv = (i >= 3) ? 4'(1 << (i - 3)) : 4'b0000;
      chk("all4_gnt", 32'(bus_a.o_gnt), 32'(exp_g));
      chk("all4_rvalid", 32'(bus_a.o_rvalid), 32'(exp_rv));
      chk("all4_rom_addr", 32'(bus_a.o_rom_addr), (i <= 4) ? 32'(8'h11 * (i - 1)) : 32'h33);
      if (i >= 3) chk("all4_rdata", 32'(bus_a.o_rdata), 32'hA500 + 32'h11 * (i - 3));
      bus_a.i_req = bus_a.i_req & ~exp_rv;
    end

    // fairness: req0 and req2 held continuously
    set_addr_a(0, 8'h40);
    set_addr_a(2, 8'h42);
    for (int k = 0; k < 4; k++) gseq[k] = 9;
    ng = 0;
    bus_a.i_req = 4'b0101;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      tick();
      if (bus_a.o_gnt != 4'b0000) begin
        gseq[ng] = gnt_idx(bus_a.o_gnt);
        ng++;
      end
    end
    bus_a.i_req = '0;
    chk("fair_count", 32'(ng), 4);
    for (int k = 0; k < 4; k++) chk("fair_order", 32'(gseq[k]), (k % 2 == 0) ? 0 : 2);
    repeat (5) tick();

    // busy mask: req1 held through its read
    set_addr_a(1, 8'h55);
    n1   = 0;
    seen = 1'b0;
    bus_a.i_req = 4'b0010;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (bus_a.o_gnt[1]) n1++;
      if (bus_a.o_rvalid[1]) seen = 1'b1;
    end
    chk("busy_rvalid_seen", 32'(seen), 1);
    chk("busy_one_gnt", 32'(n1), 1);
    chk("busy_rdata", 32'(bus_a.o_rdata), 32'hA555);
    tick();
    chk("busy_gap", 32'(bus_a.o_gnt), 0);
    tick();
    chk("busy_regrant", 32'(bus_a.o_gnt), 32'b0010);
    bus_a.i_req = '0;
    tick();
    tick();
    chk("busy_rv2", 32'(bus_a.o_rvalid), 32'b0010);
    tick();

    // pointer vs fixed priority, requests dropped right after grant
`ifdef SONG_ROM_ARB_FIXED_PRIO_EN
    g_first = 4'b0001; a_first = 8'h60; g_second = 4'b1000; a_second = 8'h63;
`else
    g_first = 4'b1000; a_first = 8'h63; g_second = 4'b0001; a_second = 8'h60;
`endif
    set_addr_a(0, 8'h60);
    set_addr_a(3, 8'h63);
    bus_a.i_req = 4'b1001;
    tick();
    chk("prio_gnt1", 32'(bus_a.o_gnt), 32'(g_first));
    chk("prio_addr1", 32'(bus_a.o_rom_addr), 32'(a_first));
    tick();
    chk("prio_gnt2", 32'(bus_a.o_gnt), 32'(g_second));
    chk("prio_addr2", 32'(bus_a.o_rom_addr), 32'(a_second));
    bus_a.i_req = '0;
    tick();
    chk("drop_rv1", 32'(bus_a.o_rvalid), 32'(g_first));
    chk("drop_rdata1", 32'(bus_a.o_rdata), 32'(rom_f(a_first)));
    tick();
    chk("drop_rv2", 32'(bus_a.o_rvalid), 32'(g_second));
    chk("drop_rdata2", 32'(bus_a.o_rdata), 32'(rom_f(a_second)));
    tick();
    chk("drop_rv_idle", 32'(bus_a.o_rvalid), 0);

    // reset mid-flight
    set_addr_a(3, 8'h77);
    bus_a.i_req = 4'b1000;
    tick();
    chk("mid_gnt3", 32'(bus_a.o_gnt), 32'b1000);
    bus_a.i_req = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", 32'(bus_a.o_rvalid), 0);
    chk("mid_rst_gnt", 32'(bus_a.o_gnt), 0);
    chk("mid_rst_rdata", 32'(bus_a.o_rdata), 0);
    chk("mid_rst_rom_addr", 32'(bus_a.o_rom_addr), 0);
    rst = 1'b0;
    tick();
    chk("mid_post_rv_a", 32'(bus_a.o_rvalid), 0);
    tick();
    chk("mid_post_rv_b", 32'(bus_a.o_rvalid), 0);
    set_addr_a(2, 8'h2A);
    bus_a.i_req = 4'b0100;
    tick();
    chk("mid_new_gnt", 32'(bus_a.o_gnt), 32'b0100);
    chk("mid_new_addr", 32'(bus_a.o_rom_addr), 32'h2A);
    tick();
    tick();
    chk("mid_new_rv", 32'(bus_a.o_rvalid), 32'b0100);
    chk("mid_new_rdata", 32'(bus_a.o_rdata), 32'hA52A);
    bus_a.i_req = '0;

    // ROM_LATENCY = 3
    bus_b.i_addr = 32'h0000_0010;
    bus_b.i_req  = 4'b0001;
    tick();
    chk("lat3_gnt", 32'(bus_b.o_gnt), 32'b0001);
    chk("lat3_addr", 32'(bus_b.o_rom_addr), 32'h10);
    tick();
    tick();
    chk("lat3_rv_t3", 32'(bus_b.o_rvalid), 0);
    tick();
    chk("lat3_rv_t4", 32'(bus_b.o_rvalid), 0);
    tick();
    chk("lat3_rv_t5", 32'(bus_b.o_rvalid), 32'b0001);
    chk("lat3_rdata", 32'(bus_b.o_rdata), 32'hA510);
    bus_b.i_req = '0;
    tick();
    chk("lat3_rv_t6", 32'(bus_b.o_rvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/song_rom_arbiter.md
Name: song_rom_arbiter

Overview:
- Shares one synchronous song ROM (header/order/pattern words) between NUM_REQ channel pattern sequencers, so the player holds a single ROM copy for multi-channel playback.
- Pipelined round-robin arbiter: at most one ROM read issued per cycle.
- Each read returns to its requester tagged by a per-requester valid pulse.
- Sits between the channel sequencers and the ROM/BRAM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width.
- DATA_W, 16, ROM data width.
- ROM_LATENCY, 1, cycles from ROM sampling an address to data valid on i_rom_data (1..3).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  NUM_REQ  per-requester read request (level)
- i_addr  in  NUM_REQ*ADDR_W  requester k address at bits [k*ADDR_W +: ADDR_W]
- o_gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
- o_rvalid  out  NUM_REQ  one-hot, one-cycle pulse: o_rdata belongs to that requester
- o_rdata  out  DATA_W  registered read data, shared by all requesters
- o_rom_addr  out  ADDR_W  registered ROM address
- i_rom_data  in  DATA_W  ROM read data

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous, active-high.
- Reset values:
  - o_gnt=0, o_rvalid=0, o_rdata=0, o_rom_addr=0.
  - busy[]=0, tag pipeline valids=0, round-robin pointer=0.
- Eligibility: requester k is eligible when i_req[k]=1 and busy[k]=0.
- Requester contract: hold i_req[k] and its address stable from assertion until the o_rvalid[k] cycle.
  - If i_req[k] is still high in the cycle after o_rvalid[k], that is a new request.
- Arbitration (combinational, cycle T):
  - Winner is the first eligible index searching ptr, ptr+1, ... modulo NUM_REQ.
  - No eligible requester means no issue.
- Issue, at the edge ending cycle T (visible in T+1):
  - o_rom_addr <= addr[winner]; o_gnt[winner]=1 for T+1 only; busy[winner] <= 1.
  - ptr <= (winner+1) mod NUM_REQ.
  - Tag pipeline stage 0 <= {valid=1, id=winner}.
- Idle cycles:
  - o_rom_addr holds its last value and o_gnt=0.
  - Pipeline stage 0 valid=0; ptr is unchanged.
- Tag pipeline: ROM_LATENCY+1 stages, shifts every cycle, never stalls.
- Return: when the last stage is valid with id=k, at that edge:
  - o_rdata <= i_rom_data; o_rvalid[k]=1 for one cycle.
  - busy[k] clears at the edge ending the o_rvalid cycle.
- Otherwise o_rvalid=0 and o_rdata holds.
- Latency: request seen in cycle T gives o_gnt in T+1 and o_rvalid/o_rdata in T+2+ROM_LATENCY (T+3 at default).
- Throughput: one grant per cycle when several requesters are eligible. Returns come back in grant order.
- Each requester has at most one read in flight, so pipeline depth never exceeds NUM_REQ.
- Simultaneous events: grant to k and return to j≠k in the same cycle are both legal. A k returning and re-granted in one cycle is impossible, because busy[k] is still set during its o_rvalid cycle.
- Requests dropped early: if i_req[k] drops after o_gnt, the read still completes and o_rvalid[k] still pulses.
- Reset mid-operation: all in-flight reads are discarded. No o_rvalid pulses after reset for pre-reset grants.

Optional Feature:
- Macro SONG_ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index always wins; ptr register removed.
- Undefined (default): round-robin as above.
- All latencies and handshakes are identical in both builds.

Test Plan:
- Single request, default params: i_req=4'b0001, addr0=8'h10, ROM returns 16'hA510 for addr 8'h10 → o_rom_addr=8'h10 and o_gnt=0001 at T+1; o_rvalid=0001 and o_rdata=16'hA510 at T+3.
- All four requesting from reset, addrs 8'h00/8'h11/8'h22/8'h33 → o_gnt order 0,1,2,3 on consecutive cycles; o_rvalid order 0,1,2,3 starting at T+3; data matches each address.
- Fairness: req0 and req2 held high continuously with immediate re-request → grants alternate 0,2,0,2. With SONG_ROM_ARB_FIXED_PRIO_EN, req0 wins whenever eligible (grant to 2 only while 0 is busy).
- Busy mask: i_req[1] held high through its read → exactly one o_gnt[1] until the o_rvalid[1] cycle; a second grant follows one cycle later.
- ROM_LATENCY=3, one request at T → o_rvalid at T+5.
- Reset mid-flight: i_rst asserted the cycle after o_gnt[3] → o_rvalid stays 0; all outputs return to reset values; a new request afterwards completes normally.
